mem_arbiter_rr: RTL and testbench

Parametrised N-way arbiter that shares one single-port synchronous RAM among N core memory ports, with registered one-hot grants, round-robin or fixed priority, and a bounded hold time. It sits between the core instances and each DRAM/IRAM macro, and replaces the fixed three-port controller. It adds per-channel read-valid strobes, zero-bubble grant handoff and starvation protection.

---
 rtl/mem_arbiter_rr.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-way arbiter sharing one single-port synchronous RAM
// among N core memory ports. Registered one-hot grant, round-robin or
// fixed priority, bounded hold time, per-channel read-valid strobes.
module mem_arbiter_rr #(
    parameter int unsigned N       = 3,
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned MODE    = 0,
    parameter int unsigned MAXHOLD = 16
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic [N-1:0]    rden,
    input  logic [N-1:0]    wren,
    input  logic [N*AW-1:0] Address,
    input  logic [N*DW-1:0] Din,
    output logic [N-1:0]    acq,
    output logic [N-1:0]    rvalid,
    output logic [N*DW-1:0] Dq,
    output logic [AW-1:0]   RAMAddress,
    output logic [DW-1:0]   RAMDin,
    output logic            RAMwren,
    input  logic [DW-1:0]   RAMq
);

    localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;
    localparam logic [OW-1:0] LAST_IDX = OW'(N - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD);
    localparam logic [HW-1:0] HOLD_LIM = (MAXHOLD > 0) ? HW'(MAXHOLD - 1) : '0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [N-1:0]    acq_d;

    logic [N-1:0]    req;
    logic [N-1:0]    own_mask;
    logic [N-1:0]    others;
    logic            own_rd;
    logic            own_wr;
    logic            own_req;
    logic [AW-1:0]   own_addr;
    logic [DW-1:0]   own_din;
    logic [OW-1:0]   search_start;
    logic            limit_hit;
    logic            rd_issue;
    logic [DW-1:0]   dq_hold [N];

    // First requester found scanning upward from start, wrapping at N.
    function automatic logic [OW-1:0] pick(input logic [N-1:0] r, input logic [OW-1:0] start);
        logic [OW-1:0] win;
        logic [OW-1:0] cand;
        logic          found;
        int unsigned   idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(start) + k;
            if (idx >= N) idx = idx - N;
            cand = OW'(idx);
            if (!found && r[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign req = rden | wren;

    // Select the current owner's request, address and data.
    always_comb begin
        own_rd   = 1'b0;
        own_wr   = 1'b0;
        own_addr = '0;
        own_din  = '0;
        own_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == OW'(i)) begin
                own_rd      = rden[i];
                own_wr      = wren[i];
                own_addr    = Address[i*AW +: AW];
                own_din     = Din[i*DW +: DW];
                own_mask[i] = 1'b1;
            end
        end
    end

    assign own_req = own_rd | own_wr;
    assign others  = req & ~own_mask;
    // Hold counter saturates at MAXHOLD, so both values mean the limit is reached.
    assign limit_hit = (MAXHOLD != 0) && ((hold_q == HOLD_LIM) || (hold_q == HOLD_MAX));
    assign search_start = (MODE == 1) ? '0 :
                          ((last_q == LAST_IDX) ? '0 : last_q + OW'(1));

    // Next-state, owner selection and hold counting.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        acq_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_GRANT;
                    owner_d = pick(req, search_start);
                    last_d  = owner_d;
                    hold_d  = '0;
                end
            end
            S_GRANT: begin
                if (!own_req || (limit_hit && (|others))) begin
                    // Forced release excludes the owner so another channel wins.
                    if (|others) begin
                        owner_d = pick(others, search_start);
                        last_d  = owner_d;
                        hold_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                        hold_d  = '0;
                    end
                end else if ((MAXHOLD != 0) && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_GRANT) begin
            for (int i = 0; i < N; i++) begin
                acq_d[i] = (owner_d == OW'(i));
            end
        end
    end

    // Arbitration state and registered grant.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= LAST_IDX;
            hold_q  <= '0;
            acq     <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            acq     <= acq_d;
        end
    end

    // RAM port follows the owner while granted; write wins over read.
    always_comb begin
        RAMAddress = '0;
        RAMDin     = '0;
        RAMwren    = 1'b0;
        if (state_q == S_GRANT) begin
            RAMAddress = own_addr;
            RAMDin     = own_din;
            RAMwren    = own_wr;
        end
    end

    assign rd_issue = (state_q == S_GRANT) && own_rd && !own_wr;

    // Read-valid strobe one cycle after issue; capture returned data per channel.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= '0;
            for (int i = 0; i < N; i++) dq_hold[i] <= '0;
        end else begin
            rvalid <= rd_issue ? acq : '0;
            for (int i = 0; i < N; i++) begin
                if (rvalid[i]) dq_hold[i] <= RAMq;
            end
        end
    end

    // Live RAM data during rvalid, otherwise the last value returned.
    always_comb begin
        Dq = '0;
        for (int i = 0; i < N; i++) begin
            Dq[i*DW +: DW] = rvalid[i] ? RAMq : dq_hold[i];
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Testbench for mem_arbiter_rr: directed stimulus with a scoreboard of
// expected grant changes, RAM writes and read returns, each tagged with
// the cycle in which it must appear.
module tb_mem_arbiter_rr;

    logic        CLK = 1'b0;
    logic        rst_n;
    int          cyc = 0;

    logic [2:0]  rden_a, wren_a, acq_a, rvalid_a;
    logic [23:0] addr_a, din_a, dq_a;
    logic [7:0]  ram_addr_a, ram_din_a, ram_q_a;
    logic        ram_wren_a;

    logic [2:0]  rden_b, wren_b, acq_b, rvalid_b;
    logic [23:0] addr_b, din_b, dq_b;
    logic [7:0]  ram_addr_b, ram_din_b, ram_q_b;
    logic        ram_wren_b;

    logic [7:0]  mem_a [256];

    typedef struct { logic [2:0] v; int cyc; } gexp_t;
    typedef struct { int ch; logic [7:0] d; int cyc; } rexp_t;
    typedef struct { logic [7:0] a; logic [7:0] d; int cyc; } wexp_t;

    gexp_t gq_a[$];
    gexp_t gq_b[$];
    rexp_t rq[$];
    wexp_t wq[$];

    int checks = 0;
    int errors = 0;
    int s;
    logic [2:0] prev_a, prev_b, exp_rv;
    gexp_t ge;
    rexp_t re;
    wexp_t we;
    logic [7:0] rr_data;
    int rr_ch;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    mem_arbiter_rr #(.N(3), .AW(8), .DW(8), .MODE(0), .MAXHOLD(4)) dut_a (
        .CLK(CLK), .rst_n(rst_n), .rden(rden_a), .wren(wren_a),
        .Address(addr_a), .Din(din_a), .acq(acq_a), .rvalid(rvalid_a),
        .Dq(dq_a), .RAMAddress(ram_addr_a), .RAMDin(ram_din_a),
        .RAMwren(ram_wren_a), .RAMq(ram_q_a)
    );

    mem_arbiter_rr #(.N(3), .AW(8), .DW(8), .MODE(1), .MAXHOLD(0)) dut_b (
        .CLK(CLK), .rst_n(rst_n), .rden(rden_b), .wren(wren_b),
        .Address(addr_b), .Din(din_b), .acq(acq_b), .rvalid(rvalid_b),
        .Dq(dq_b), .RAMAddress(ram_addr_b), .RAMDin(ram_din_b),
        .RAMwren(ram_wren_b), .RAMq(ram_q_b)
    );

    // RAM model: preloaded while reset is low, 1-cycle read latency.
    always @(posedge CLK) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= (i == 5) ? 8'hA7 : ~8'(i);
        end else if (ram_wren_a) begin
            mem_a[ram_addr_a] <= ram_din_a;
        end
        ram_q_a <= mem_a[ram_addr_a];
    end

    always @(posedge CLK) ram_q_b <= ram_addr_b;

    task automatic check(input string name, input bit ok, input string act, input string req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %s, required %s", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        rst_n  = 1'b1;
        rden_a = '0; wren_a = '0; addr_a = '0; din_a = '0;
        rden_b = '0; wren_b = '0; addr_b = '0; din_b = '0;
        prev_a = '0; prev_b = '0;
        #1 rst_n = 1'b0;
        fork
            begin : monitor
                forever begin
                    @(negedge CLK);
                    if (acq_a !== prev_a) begin
                        if (gq_a.size() == 0) begin
                            check("grant_a", 1'b0, $sformatf("acq=%b cyc=%0d", acq_a, cyc), "no grant change");
                        end else begin
                            ge = gq_a.pop_front();
                            check("grant_a", (acq_a === ge.v) && (cyc == ge.cyc),
                                  $sformatf("acq=%b cyc=%0d", acq_a, cyc),
                                  $sformatf("acq=%b cyc=%0d", ge.v, ge.cyc));
                        end
                        prev_a = acq_a;
                    end
                    if (acq_b !== prev_b) begin
                        if (gq_b.size() == 0) begin
                            check("grant_b", 1'b0, $sformatf("acq=%b cyc=%0d", acq_b, cyc), "no grant change");
                        end else begin
                            ge = gq_b.pop_front();
                            check("grant_b", (acq_b === ge.v) && (cyc == ge.cyc),
                                  $sformatf("acq=%b cyc=%0d", acq_b, cyc),
                                  $sformatf("acq=%b cyc=%0d", ge.v, ge.cyc));
                        end
                        prev_b = acq_b;
                    end
                    if (rvalid_a !== 3'b000) begin
                        if (rq.size() == 0) begin
                            check("read_a", 1'b0, $sformatf("rvalid=%b cyc=%0d", rvalid_a, cyc), "no read return");
                        end else begin
                            re = rq.pop_front();
                            exp_rv = 3'(1) << re.ch;
                            check("read_a", (rvalid_a === exp_rv) && (dq_a[re.ch*8 +: 8] === re.d) && (cyc == re.cyc),
                                  $sformatf("rvalid=%b dq=%h cyc=%0d", rvalid_a, dq_a[re.ch*8 +: 8], cyc),
                                  $sformatf("rvalid=%b dq=%h cyc=%0d", exp_rv, re.d, re.cyc));
                        end
                    end
                    if (ram_wren_a === 1'b1) begin
                        if (wq.size() == 0) begin
                            check("write_a", 1'b0, $sformatf("addr=%h din=%h cyc=%0d", ram_addr_a, ram_din_a, cyc), "no write");
                        end else begin
                            we = wq.pop_front();
                            check("write_a", (ram_addr_a === we.a) && (ram_din_a === we.d) && (cyc == we.cyc),
                                  $sformatf("addr=%h din=%h cyc=%0d", ram_addr_a, ram_din_a, cyc),
                                  $sformatf("addr=%h din=%h cyc=%0d", we.a, we.d, we.cyc));
                        end
                    end
                end
            end
            begin : stimulus
                // Reset state: every output of both instances at zero.
                repeat (3) @(posedge CLK);
                #2;
                check("rst_acq",     acq_a === 3'b000,     $sformatf("%b", acq_a),     "000");
                check("rst_rvalid",  rvalid_a === 3'b000,  $sformatf("%b", rvalid_a),  "000");
                check("rst_dq",      dq_a === 24'h0,       $sformatf("%h", dq_a),      "000000");
                check("rst_ramaddr", ram_addr_a === 8'h00, $sformatf("%h", ram_addr_a), "00");
                check("rst_ramdin",  ram_din_a === 8'h00,  $sformatf("%h", ram_din_a), "00");
                check("rst_ramwren", ram_wren_a === 1'b0,  $sformatf("%b", ram_wren_a), "0");
                check("rst_acq_b",   acq_b === 3'b000,     $sformatf("%b", acq_b),     "000");
                @(negedge CLK);
                rst_n = 1'b1;

                // Single read by ch1 from address 0x05.
                tick(1);
                s = cyc;
                rden_a[1] = 1'b1;
                addr_a[15:8] = 8'h05;
                gq_a.push_back('{3'b010, s + 1});
                rq.push_back('{1, 8'hA7, s + 2});
                gq_a.push_back('{3'b000, s + 3});
                tick(2);
                rden_a = '0;
                addr_a = '0;
                tick(2);
                check("dq_hold_ch1", dq_a[15:8] === 8'hA7, $sformatf("%h", dq_a[15:8]), "a7");
                check("rvalid_idle", rvalid_a === 3'b000,  $sformatf("%b", rvalid_a),   "000");

                // Asynchronous reset while a read return is pending.
                s = cyc;
                rden_a[2] = 1'b1;
                addr_a[23:16] = 8'h22;
                gq_a.push_back('{3'b100, s + 1});
                gq_a.push_back('{3'b000, s + 2});
                tick(2);
                check("pre_rst_rvalid", rvalid_a === 3'b100, $sformatf("%b", rvalid_a), "100");
                rst_n  = 1'b0;
                rden_a = '0;
                addr_a = '0;
                #1;
                check("async_rvalid",  rvalid_a === 3'b000,  $sformatf("%b", rvalid_a),   "000");
                check("async_acq",     acq_a === 3'b000,     $sformatf("%b", acq_a),      "000");
                check("async_ramaddr", ram_addr_a === 8'h00, $sformatf("%h", ram_addr_a), "00");
                check("async_dq",      dq_a === 24'h0,       $sformatf("%h", dq_a),       "000000");
                @(negedge CLK);
                @(negedge CLK);
                rst_n = 1'b1;

                // Round-robin with all three reading, 4 granted cycles each.
                tick(1);
                s = cyc;
                rden_a = 3'b111;
                addr_a = {8'h22, 8'h21, 8'h20};
                gq_a.push_back('{3'b001, s + 1});
                gq_a.push_back('{3'b010, s + 5});
                gq_a.push_back('{3'b100, s + 9});
                gq_a.push_back('{3'b001, s + 13});
                gq_a.push_back('{3'b010, s + 17});
                gq_a.push_back('{3'b000, s + 18});
                for (int k = 0; k < 16; k++) begin
                    rr_ch = (k / 4) % 3;
                    case (rr_ch)
                        0:       rr_data = 8'hDF;
                        1:       rr_data = 8'hDE;
                        default: rr_data = 8'hDD;
                    endcase
                    rq.push_back('{rr_ch, rr_data, s + 2 + k});
                end
                tick(17);
                rden_a = '0;
                addr_a = '0;
                tick(3);

                // Write 0x3C to 0x10, read it back, then a write+read collision.
                s = cyc;
                wren_a[0] = 1'b1;
                din_a[7:0] = 8'h3C;
                addr_a[7:0] = 8'h10;
                gq_a.push_back('{3'b001, s + 1});
                wq.push_back('{8'h10, 8'h3C, s + 1});
                tick(2);
                wren_a[0] = 1'b0;
                rden_a[0] = 1'b1;
                rq.push_back('{0, 8'h3C, s + 3});
                tick(1);
                wren_a[0] = 1'b1;
                din_a[7:0] = 8'h55;
                addr_a[7:0] = 8'h11;
                wq.push_back('{8'h11, 8'h55, s + 3});
                tick(1);
                rden_a = '0;
                wren_a = '0;
                addr_a = '0;
                din_a  = '0;
                gq_a.push_back('{3'b000, s + 5});
                tick(3);

                // Sole owner past the hold limit keeps the grant.
                s = cyc;
                wren_a[1] = 1'b1;
                addr_a[15:8] = 8'h30;
                din_a[15:8] = 8'h66;
                gq_a.push_back('{3'b010, s + 1});
                for (int k = 1; k <= 10; k++) wq.push_back('{8'h30, 8'h66, s + k});
                tick(11);
                wren_a = '0;
                addr_a = '0;
                din_a  = '0;
                gq_a.push_back('{3'b000, s + 12});
                tick(3);

                // Fixed priority, unlimited hold: ch0 wins after ch2 drops and keeps it.
                s = cyc;
                rden_b = 3'b100;
                gq_b.push_back('{3'b100, s + 1});
                tick(2);
                rden_b = 3'b111;
                tick(2);
                rden_b = 3'b011;
                gq_b.push_back('{3'b001, s + 5});
                tick(31);
                rden_b = '0;
                gq_b.push_back('{3'b000, s + 36});
                tick(3);
            end
        join_any
        disable fork;
        check("grant_a_drained", gq_a.size() == 0, $sformatf("%0d left", gq_a.size()), "0 left");
        check("grant_b_drained", gq_b.size() == 0, $sformatf("%0d left", gq_b.size()), "0 left");
        check("read_drained",    rq.size() == 0,   $sformatf("%0d left", rq.size()),   "0 left");
        check("write_drained",   wq.size() == 0,   $sformatf("%0d left", wq.size()),   "0 left");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
